// File: rtl/hash_unpack.sv
// Unpacks an 8112-bit vector of 12-bit fields into 13-bit coefficient-memory writes, one per cycle.
// Optional HASH_UNPACK_ROUNDED_EN selects the Rounded centred decode instead of zero extension.
module hash_unpack (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [10:0]   degp,
    input  logic [8111:0] hash_data,
    output logic [10:0]   mem_address_o,
    output logic [12:0]   mem_input,
    output logic          mem_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [10:0] MAX_N = 11'd676;

    state_t        state;
    state_t        state_next;
    logic [8111:0] shift_reg;
    logic [10:0]   n;
    logic [10:0]   i;
    logic [10:0]   n_clamp;
    logic [12:0]   dec;

    assign n_clamp = (degp > MAX_N) ? MAX_N : degp;

`ifdef HASH_UNPACK_ROUNDED_EN
    // 3u - 2295, wrapped to 13 bits: centred two's-complement coefficient for q=4591
    assign dec = {1'b0, shift_reg[11:0]} + {shift_reg[11:0], 1'b0} - 13'd2295;
`else
    assign dec = {1'b0, shift_reg[11:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            n         <= '0;
            i         <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= hash_data;
                        n         <= n_clamp;
                        i         <= '0;
                    end
                end
                WRITE: begin
                    shift_reg <= {12'b0, shift_reg[8111:12]};
                    i         <= i + 11'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        mem_we        = 1'b0;
        mem_address_o = '0;
        mem_input     = '0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (n_clamp != 11'd0) ? WRITE : DONE;
            end
            WRITE: begin
                busy          = 1'b1;
                mem_we        = 1'b1;
                mem_address_o = i;
                mem_input     = dec;
                if (i == n - 11'd1) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hash_unpack.sv
// Scoreboard bench for hash_unpack: stimulus queues expected writes and done timing,
// a negedge monitor pops and compares whenever the DUT writes or pulses done.
module tb_hash_unpack;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [10:0]   degp;
    logic [8111:0] hash_data;
    logic [10:0]   mem_address_o;
    logic [12:0]   mem_input;
    logic          mem_we;
    logic          busy;
    logic          done;

    hash_unpack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .degp          (degp),
        .hash_data     (hash_data),
        .mem_address_o (mem_address_o),
        .mem_input     (mem_input),
        .mem_we        (mem_we),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [10:0] a;
        logic [12:0] d;
    } wr_t;

    typedef struct {
        int cyc;
        int span;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int busy_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [12:0] exp_dec(input logic [11:0] u);
`ifdef HASH_UNPACK_ROUNDED_EN
        int t;
        t = 3 * int'(u) - 2295;
        return 13'(t & 8191);
`else
        return {1'b0, u};
`endif
    endfunction

    task automatic push_wr(input int a, input logic [12:0] d);
        wr_t w;
        w.a = 11'(a);
        w.d = d;
        wq.push_back(w);
    endtask

    task automatic start_run(input logic [8111:0] h, input logic [10:0] d, input int n, input bit keep);
        dn_t e;
        @(negedge clk);
        hash_data = h;
        degp      = d;
        start     = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
        e.cyc  = cyc + n;
        e.span = n + 1;
        dq.push_back(e);
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (dq.size() != 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        chk("done_wait", dq.size(), 0);
        chk("writes_left", wq.size(), 0);
    endtask

    // Monitor: every output cycle out of reset is checked against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            wr_t w;
            dn_t e;
            if (busy) busy_cnt++;
            if (mem_we) begin
                if (wq.size() == 0) chk("unexpected_write", {21'd0, mem_address_o}, 32'hFFFF_FFFF);
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", {21'd0, mem_address_o}, {21'd0, w.a});
                    chk("wr_data", {19'd0, mem_input}, {19'd0, w.d});
                end
            end else begin
                chk("idle_addr", {21'd0, mem_address_o}, 0);
                chk("idle_data", {19'd0, mem_input}, 0);
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = dq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_span", busy_cnt, e.span);
                    chk("done_we", {31'd0, mem_we}, 0);
                end
            end
            if (!busy) busy_cnt = 0;
        end
    end

    initial begin
        logic [8111:0] h;
        rst_n     = 1'b0;
        start     = 1'b0;
        degp      = '0;
        hash_data = '0;
        #12;
        chk("rst_we",   {31'd0, mem_we}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_addr", {21'd0, mem_address_o}, 0);
        chk("rst_data", {19'd0, mem_input}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // full 676-field run, field k = k
        h = '0;
        for (int k = 0; k < 676; k++) begin
            h[12*k +: 12] = 12'(k);
            push_wr(k, exp_dec(12'(k)));
        end
        start_run(h, 11'd676, 676, 1'b0);
        wait_done(700);

        // small directed run with boundary field values
        h = '0;
        h[11:0]  = 12'hFFF;
        h[23:12] = 12'h001;
        h[35:24] = 12'h800;
        push_wr(0, exp_dec(12'hFFF));
        push_wr(1, exp_dec(12'h001));
        push_wr(2, exp_dec(12'h800));
        start_run(h, 11'd3, 3, 1'b0);
        wait_done(20);

        // degp = 0: done only
        start_run('0, 11'd0, 0, 1'b0);
        wait_done(10);

        // start held high and inputs changed during a 10-word run
        h = '0;
        for (int k = 0; k < 10; k++) begin
            h[12*k +: 12] = 12'(k + 100);
            push_wr(k, exp_dec(12'(k + 100)));
        end
        start_run(h, 11'd10, 10, 1'b1);
        hash_data = '1;
        degp      = 11'd1000;
        wait_done(30);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        chk("no_restart", wq.size() + dq.size(), 0);

        // degp beyond the field count clamps to 676 words
        h = '0;
        for (int k = 0; k < 676; k++) begin
            h[12*k +: 12] = 12'(4095 - k);
            push_wr(k, exp_dec(12'(4095 - k)));
        end
        start_run(h, 11'd1000, 676, 1'b0);
        wait_done(700);

        // reset during write 5 of a 20-word run
        h = '0;
        for (int k = 0; k < 20; k++) begin
            h[12*k +: 12] = 12'(3 * k);
            push_wr(k, exp_dec(12'(3 * k)));
        end
        start_run(h, 11'd20, 20, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        chk("pre_reset_q", wq.size(), 15);
        chk("pre_reset_addr", {21'd0, mem_address_o}, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",   {31'd0, mem_we}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_addr", {21'd0, mem_address_o}, 0);
        chk("mid_rst_data", {19'd0, mem_input}, 0);
        wq.delete();
        dq.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        chk("post_rst_idle", {31'd0, busy}, 0);

        h = '0;
        for (int k = 0; k < 3; k++) begin
            h[12*k +: 12] = 12'(k + 7);
            push_wr(k, exp_dec(12'(k + 7)));
        end
        start_run(h, 11'd3, 3, 1'b0);
        wait_done(20);

`ifdef HASH_UNPACK_ROUNDED_EN
        h = '0;
        h[11:0]  = 12'd0;
        h[23:12] = 12'd765;
        h[35:24] = 12'd1530;
        h[47:36] = 12'd4095;
        push_wr(0, 13'h1709);
        push_wr(1, 13'h0000);
        push_wr(2, 13'h08F7);
        push_wr(3, 13'h0706);
        start_run(h, 11'd4, 4, 1'b0);
        wait_done(20);
`endif

        repeat (3) @(posedge clk);
        chk("final_queues", wq.size() + dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
